// File: rtl/debug_pkg.sv
// Shared definitions for the debug trace capture block.
// Record width depends on DBG_TRACE_TIMESTAMP_EN (timestamp prepended when defined).
package debug_pkg;

    localparam int TS_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_t;

    function automatic int rec_width(input int ch_w, input int frame_w);
`ifdef DBG_TRACE_TIMESTAMP_EN
        return TS_W + ch_w + frame_w;
`else
        return ch_w + frame_w;
`endif
    endfunction

endpackage

// File: rtl/trace_ring_buffer.sv
// Circular record store: overwrite-oldest push, registered pop, synchronous clear.
module trace_ring_buffer #(
    parameter int DEPTH = 8,
    parameter int REC_W = 11,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [REC_W-1:0] push_data,
    input  logic             pop,
    output logic [REC_W-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [REC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [REC_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (count_reg == FULL) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end else if (pop && (count_reg != '0)) begin
            rd_data_reg <= mem[rd_ptr_reg];
            rd_ptr_reg  <= rd_ptr_reg + 1'b1;
            count_reg   <= count_reg - 1'b1;
        end
    end

    assign rd_data = rd_data_reg;
    assign count   = count_reg;

endmodule

// File: rtl/debug_trace_capture.sv
// Live debug tap plus trigger-armed trace buffer of {channel, frame} records.
// Define DBG_TRACE_TIMESTAMP_EN to prepend a 16-bit cycle timestamp to each record.
module debug_trace_capture
    import debug_pkg::*;
#(
    parameter int FRAME_W = 9,
    parameter int DATA_W  = 4,
    parameter int CH_W    = 2,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = $clog2(DEPTH + 1),
    localparam int REC_W  = rec_width(CH_W, FRAME_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               debug,
    input  logic               frame_valid,
    input  logic [FRAME_W-1:0] frame,
    input  logic               data_out_valid,
    input  logic [DATA_W-1:0]  data_out,
    input  logic [CH_W-1:0]    channel,
    input  logic               arm,
    input  logic [FRAME_W-1:0] trig_mask,
    input  logic [FRAME_W-1:0] trig_value,
    input  logic [CNT_W-1:0]   post_cnt,
    input  logic               rd_en,
    output logic [FRAME_W-1:0] debug_frame,
    output logic [DATA_W-1:0]  debug_reg,
    output logic [CH_W-1:0]    debug_ch,
    output logic [1:0]         trace_state,
    output logic [CNT_W-1:0]   count,
    output logic [REC_W-1:0]   rd_data,
    output logic               rd_valid
);

    trace_state_t       state_reg, state_next;
    logic [CNT_W-1:0]   remaining_reg, remaining_next;
    logic [FRAME_W-1:0] frame_reg;
    logic [DATA_W-1:0]  reg_reg;
    logic [CH_W-1:0]    ch_reg;
    logic               rd_valid_reg;
    logic               buf_clear, buf_push, buf_pop;
    logic [CNT_W-1:0]   buf_count;
    logic [REC_W-1:0]   push_rec;
    logic               trig_hit;

    assign trig_hit = ((frame ^ trig_value) & trig_mask) == '0;

`ifdef DBG_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_reg <= '0;
        end else if (!debug || arm) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_reg + 1'b1;
        end
    end

    assign push_rec = {ts_reg, channel, frame};
`else
    assign push_rec = {channel, frame};
`endif

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        buf_clear      = 1'b0;
        buf_push       = 1'b0;
        buf_pop        = 1'b0;
        if (!debug) begin
            state_next     = ST_IDLE;
            remaining_next = '0;
            buf_clear      = 1'b1;
        end else if (arm) begin
            state_next = ST_ARMED;
            buf_clear  = 1'b1;
        end else begin
            case (state_reg)
                ST_ARMED: begin
                    if (frame_valid) begin
                        buf_push = 1'b1;
                        if (trig_hit) begin
                            if (post_cnt == '0) begin
                                state_next = ST_DONE;
                            end else begin
                                remaining_next = post_cnt;
                                state_next     = ST_POST;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (frame_valid) begin
                        buf_push       = 1'b1;
                        remaining_next = remaining_reg - 1'b1;
                        if (remaining_reg == CNT_W'(1)) begin
                            state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    buf_pop = rd_en && (buf_count != '0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            frame_reg     <= '0;
            reg_reg       <= '0;
            ch_reg        <= '0;
            rd_valid_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            rd_valid_reg  <= buf_pop;
            if (!debug) begin
                frame_reg <= '0;
                reg_reg   <= '0;
                ch_reg    <= '0;
            end else begin
                if (frame_valid) begin
                    frame_reg <= frame;
                end
                if (data_out_valid) begin
                    reg_reg <= data_out;
                end
                ch_reg <= channel;
            end
        end
    end

    trace_ring_buffer #(
        .DEPTH (DEPTH),
        .REC_W (REC_W),
        .CNT_W (CNT_W)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .clear     (buf_clear),
        .push      (buf_push),
        .push_data (push_rec),
        .pop       (buf_pop),
        .rd_data   (rd_data),
        .count     (buf_count)
    );

    assign debug_frame = frame_reg;
    assign debug_reg   = reg_reg;
    assign debug_ch    = ch_reg;
    assign trace_state = state_reg;
    assign count       = buf_count;
    assign rd_valid    = rd_valid_reg;

endmodule

// File: tb/tb_debug_trace_capture.sv
// Self-checking bench for debug_trace_capture: directed scenarios plus randomized run vs a queue model.
module tb_debug_trace_capture;
    import debug_pkg::*;

    localparam int FRAME_W = 9;
    localparam int DATA_W  = 4;
    localparam int CH_W    = 2;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 4;
    localparam int REC_W   = rec_width(CH_W, FRAME_W);

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               debug = 1'b0;
    logic               frame_valid = 1'b0;
    logic [FRAME_W-1:0] frame = '0;
    logic               data_out_valid = 1'b0;
    logic [DATA_W-1:0]  data_out = '0;
    logic [CH_W-1:0]    channel = '0;
    logic               arm = 1'b0;
    logic [FRAME_W-1:0] trig_mask = '0;
    logic [FRAME_W-1:0] trig_value = '0;
    logic [CNT_W-1:0]   post_cnt = '0;
    logic               rd_en = 1'b0;
    logic [FRAME_W-1:0] debug_frame;
    logic [DATA_W-1:0]  debug_reg;
    logic [CH_W-1:0]    debug_ch;
    logic [1:0]         trace_state;
    logic [CNT_W-1:0]   count;
    logic [REC_W-1:0]   rd_data;
    logic               rd_valid;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [REC_W-1:0]   m_q[$];
    int                 m_state = 0;
    int                 m_rem = 0;
    logic [FRAME_W-1:0] m_frame = '0;
    logic [DATA_W-1:0]  m_reg = '0;
    logic [CH_W-1:0]    m_ch = '0;
    logic [REC_W-1:0]   m_rd_data = '0;
    logic               m_rd_valid = 1'b0;
`ifdef DBG_TRACE_TIMESTAMP_EN
    logic [15:0]        m_ts = '0;
`endif

    debug_trace_capture dut (
        .clk            (clk),
        .rst            (rst),
        .debug          (debug),
        .frame_valid    (frame_valid),
        .frame          (frame),
        .data_out_valid (data_out_valid),
        .data_out       (data_out),
        .channel        (channel),
        .arm            (arm),
        .trig_mask      (trig_mask),
        .trig_value     (trig_value),
        .post_cnt       (post_cnt),
        .rd_en          (rd_en),
        .debug_frame    (debug_frame),
        .debug_reg      (debug_reg),
        .debug_ch       (debug_ch),
        .trace_state    (trace_state),
        .count          (count),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid)
    );

    always #5 clk = ~clk;

    // Applies one clock edge of behaviour to the model using the current inputs.
    task automatic model_step();
        logic [REC_W-1:0] rec;
`ifdef DBG_TRACE_TIMESTAMP_EN
        rec = {m_ts, channel, frame};
`else
        rec = {channel, frame};
`endif
        if (!rst) begin
            m_q.delete();
            m_state = 0; m_rem = 0;
            m_frame = '0; m_reg = '0; m_ch = '0;
            m_rd_data = '0; m_rd_valid = 1'b0;
`ifdef DBG_TRACE_TIMESTAMP_EN
            m_ts = '0;
`endif
        end else if (!debug) begin
            m_q.delete();
            m_state = 0; m_rem = 0;
            m_frame = '0; m_reg = '0; m_ch = '0;
            m_rd_valid = 1'b0;
`ifdef DBG_TRACE_TIMESTAMP_EN
            m_ts = '0;
`endif
        end else begin
            m_rd_valid = 1'b0;
            if (frame_valid) m_frame = frame;
            if (data_out_valid) m_reg = data_out;
            m_ch = channel;
            if (arm) begin
                m_q.delete();
                m_state = 1;
            end else begin
                case (m_state)
                    1: if (frame_valid) begin
                        m_q.push_back(rec);
                        if (m_q.size() > DEPTH) m_q.delete(0);
                        if (((frame ^ trig_value) & trig_mask) == 0) begin
                            if (post_cnt == 0) m_state = 3;
                            else begin
                                m_rem = int'(post_cnt);
                                m_state = 2;
                            end
                        end
                    end
                    2: if (frame_valid) begin
                        m_q.push_back(rec);
                        if (m_q.size() > DEPTH) m_q.delete(0);
                        m_rem = m_rem - 1;
                        if (m_rem == 0) m_state = 3;
                    end
                    3: if (rd_en && m_q.size() > 0) begin
                        m_rd_data = m_q.pop_front();
                        m_rd_valid = 1'b1;
                    end
                    default: ;
                endcase
            end
`ifdef DBG_TRACE_TIMESTAMP_EN
            if (arm) m_ts = '0;
            else m_ts = m_ts + 16'd1;
`endif
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic quiet_inputs();
        arm = 1'b0; frame_valid = 1'b0; data_out_valid = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; debug = 1'b1;
        quiet_inputs();
        frame_valid = 1'b1; frame = 9'h03C; data_out_valid = 1'b1; data_out = 4'h5; channel = 2'd3;
        cycle();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        cycle();
        cycle();
        #2;
        rst = 1'b0;
        model_step();
        #1;
        checks++; if (debug_frame !== '0) begin failures++; $display("FAIL reset_debug_frame got=%h exp=0", debug_frame); end
        checks++; if (debug_reg !== '0) begin failures++; $display("FAIL reset_debug_reg got=%h exp=0", debug_reg); end
        checks++; if (debug_ch !== '0) begin failures++; $display("FAIL reset_debug_ch got=%h exp=0", debug_ch); end
        checks++; if (trace_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", trace_state); end
        checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (rd_valid !== 1'b0 || rd_data !== '0) begin failures++; $display("FAIL reset_rd got=%b/%h exp=0/0", rd_valid, rd_data); end
        quiet_inputs();
        cycle();
        rst = 1'b1; debug = 1'b1;
        frame_valid = 1'b1; frame = 9'h1A5; channel = 2'd2;
        cycle();
        $display("reset release: debug_frame=%h debug_ch=%0d", debug_frame, debug_ch);
        checks++; if (debug_frame !== 9'h1A5) begin failures++; $display("FAIL enable_debug_frame got=%h exp=1a5", debug_frame); end
        checks++; if (debug_ch !== 2'd2) begin failures++; $display("FAIL enable_debug_ch got=%0d exp=2", debug_ch); end
        checks++; if (trace_state !== 2'd0 || count !== '0) begin failures++; $display("FAIL enable_idle got=%0d/%0d exp=0/0", trace_state, count); end
        quiet_inputs();
    endtask

    task automatic test_pre_trigger_wrap();
        int exp_frames[8] = '{6, 7, 8, 9, 10, 'h0FF, 'h20, 'h21};
        quiet_inputs();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        checks++; if (trace_state !== 2'd1 || count !== '0) begin failures++; $display("FAIL wrap_armed got=%0d/%0d exp=1/0", trace_state, count); end
        trig_mask = 9'h1FF; trig_value = 9'h0FF; post_cnt = 4'd2; channel = 2'd1;
        for (int i = 1; i <= 10; i++) begin
            frame_valid = 1'b1; frame = FRAME_W'(i);
            cycle();
        end
        frame = 9'h0FF;
        cycle();
        checks++; if (trace_state !== 2'd2) begin failures++; $display("FAIL wrap_post_state got=%0d exp=2", trace_state); end
        frame = 9'h020;
        cycle();
        frame = 9'h021;
        cycle();
        frame_valid = 1'b0;
        checks++; if (trace_state !== 2'd3 || count !== 4'd8) begin failures++; $display("FAIL wrap_done got=%0d/%0d exp=3/8", trace_state, count); end
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            cycle();
            $display("pop %0d: rd_valid=%b frame=%h", i, rd_valid, rd_data[FRAME_W-1:0]);
            checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL wrap_pop_valid[%0d] got=%b exp=1", i, rd_valid); end
            checks++; if (rd_data[FRAME_W-1:0] !== FRAME_W'(exp_frames[i]) || rd_data !== m_rd_data) begin
                failures++; $display("FAIL wrap_pop_data[%0d] got=%h exp_frame=%h exp_rec=%h", i, rd_data, exp_frames[i], m_rd_data);
            end
        end
        rd_en = 1'b0;
        cycle();
        checks++; if (rd_valid !== 1'b0 || count !== '0) begin failures++; $display("FAIL wrap_drained got=%b/%0d exp=0/0", rd_valid, count); end
    endtask

    task automatic test_empty_read();
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL empty_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (rd_data[FRAME_W-1:0] !== 9'h021 || rd_data !== m_rd_data) begin failures++; $display("FAIL empty_rd_hold got=%h exp=%h", rd_data, m_rd_data); end
        checks++; if (trace_state !== 2'd3 || count !== '0) begin failures++; $display("FAIL empty_state got=%0d/%0d exp=3/0", trace_state, count); end
    endtask

    task automatic test_post_zero();
        quiet_inputs();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        trig_mask = 9'h1FF; trig_value = 9'h055; post_cnt = 4'd0; channel = 2'd3;
        frame_valid = 1'b1; frame = 9'h055;
        cycle();
        checks++; if (trace_state !== 2'd3 || count !== 4'd1) begin failures++; $display("FAIL post0_done got=%0d/%0d exp=3/1", trace_state, count); end
        frame = 9'h0AA;
        cycle();
        frame_valid = 1'b0;
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL post0_no_write got=%0d exp=1", count); end
        checks++; if (debug_frame !== 9'h0AA) begin failures++; $display("FAIL post0_live got=%h exp=0aa", debug_frame); end
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data[FRAME_W+CH_W-1:0] !== {2'd3, 9'h055}) begin
            failures++; $display("FAIL post0_pop got=%b/%h exp=1/%h", rd_valid, rd_data, {2'd3, 9'h055});
        end
    endtask

    task automatic test_same_cycle_arm();
        arm = 1'b1; frame_valid = 1'b1; frame = 9'h055;
        cycle();
        quiet_inputs();
        checks++; if (trace_state !== 2'd1 || count !== '0) begin failures++; $display("FAIL arm_same_cycle got=%0d/%0d exp=1/0", trace_state, count); end
        cycle();
        checks++; if (count !== '0) begin failures++; $display("FAIL arm_hold_count got=%0d exp=0", count); end
    endtask

    task automatic test_clear_on_disable();
        quiet_inputs();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        trig_mask = 9'h1FF; trig_value = 9'h055; post_cnt = 4'd3;
        frame_valid = 1'b1; frame = 9'h055; data_out_valid = 1'b1; data_out = 4'hA;
        cycle();
        quiet_inputs();
        checks++; if (trace_state !== 2'd2 || debug_reg !== 4'hA) begin failures++; $display("FAIL disable_pre got=%0d/%h exp=2/a", trace_state, debug_reg); end
        debug = 1'b0; frame_valid = 1'b1; arm = 1'b1;
        cycle();
        quiet_inputs();
        checks++; if (trace_state !== 2'd0 || count !== '0) begin failures++; $display("FAIL disable_state got=%0d/%0d exp=0/0", trace_state, count); end
        checks++; if (debug_reg !== '0 || debug_frame !== '0 || debug_ch !== '0) begin failures++; $display("FAIL disable_live got=%h/%h/%h exp=0/0/0", debug_reg, debug_frame, debug_ch); end
        debug = 1'b1;
    endtask

`ifdef DBG_TRACE_TIMESTAMP_EN
    task automatic test_timestamp();
        quiet_inputs();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        trig_mask = '0; post_cnt = 4'd2;
        for (int i = 0; i < 3; i++) begin
            frame_valid = 1'b1; frame = FRAME_W'(9'h100 + i);
            cycle();
        end
        frame_valid = 1'b0;
        checks++; if (trace_state !== 2'd3 || count !== 4'd3) begin failures++; $display("FAIL ts_done got=%0d/%0d exp=3/3", trace_state, count); end
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1;
            cycle();
            $display("ts pop %0d: ts=%0d frame=%h", i, rd_data[REC_W-1 -: 16], rd_data[FRAME_W-1:0]);
            checks++; if (rd_data[REC_W-1 -: 16] !== 16'(i)) begin failures++; $display("FAIL ts_value[%0d] got=%0d exp=%0d", i, rd_data[REC_W-1 -: 16], i); end
        end
        rd_en = 1'b0;
    endtask
`endif

    task automatic test_random();
        int bad = 0;
        quiet_inputs();
        for (int n = 0; n < 1500; n++) begin
            debug = ($urandom_range(0, 49) != 0);
            arm = ($urandom_range(0, 29) == 0);
            if (arm) begin
                if ($urandom_range(0, 2) == 0) trig_mask = 9'h1FF;
                else trig_mask = FRAME_W'($urandom & $urandom & $urandom);
                trig_value = FRAME_W'($urandom);
                post_cnt = CNT_W'($urandom_range(0, 11));
            end
            frame_valid = $urandom_range(0, 1);
            frame = FRAME_W'($urandom);
            data_out_valid = $urandom_range(0, 1);
            data_out = DATA_W'($urandom);
            channel = CH_W'($urandom);
            rd_en = $urandom_range(0, 1);
            cycle();
            checks++; if (trace_state !== 2'(m_state)) begin failures++; bad++; $display("FAIL rand_state[%0d] got=%0d exp=%0d", n, trace_state, m_state); end
            checks++; if (count !== CNT_W'(m_q.size())) begin failures++; bad++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", n, count, m_q.size()); end
            checks++; if (debug_frame !== m_frame || debug_reg !== m_reg || debug_ch !== m_ch) begin
                failures++; bad++; $display("FAIL rand_live[%0d] got=%h/%h/%h exp=%h/%h/%h", n, debug_frame, debug_reg, debug_ch, m_frame, m_reg, m_ch);
            end
            checks++; if (rd_valid !== m_rd_valid || rd_data !== m_rd_data) begin
                failures++; bad++; $display("FAIL rand_rd[%0d] got=%b/%h exp=%b/%h", n, rd_valid, rd_data, m_rd_valid, m_rd_data);
            end
            if (bad > 20) break;
        end
        quiet_inputs();
        debug = 1'b1;
    endtask

    initial begin
        test_reset();
        test_pre_trigger_wrap();
        test_empty_read();
        test_post_zero();
        test_same_cycle_arm();
        test_clear_on_disable();
`ifdef DBG_TRACE_TIMESTAMP_EN
        test_timestamp();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
